btb_branch_predictor: RTL and testbench
=======================================

# btb_branch_predictor

Parametrised branch predictor: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters and a mispredict counter. It replaces the fixed not-taken predictor behind the fetch stage. Fetch presents `current_pc` and receives a same-cycle prediction. Execute writes resolved branch outcomes back one update per cycle.

## Interface
Parameters:
- `NENTRIES`, 16: BTB depth. Power of two, range 2..1024.
- `IDX_BITS`, `$clog2(NENTRIES)`: derived index width. Not overridden.
- `TAG_BITS`, `30 - IDX_BITS`: derived tag width, taken from `pc[31:IDX_BITS+2]`.

Ports:
- `CLK`, input, 1: clock, rising edge.
- `nRST`, input, 1: reset, asynchronous, active-low.
- `current_pc`, input, 32: fetch PC to predict.
- `predict_taken`, output, 1: prediction for `current_pc`.
- `target_addr`, output, 32: next fetch address.
- `update_predictor`, input, 1: resolved branch update valid this cycle.
- `update_addr`, input, 32: PC of the resolved branch.
- `update_target`, input, 32: resolved branch target.
- `branch_result`, input, 1: actual outcome, 1 = taken.
- `prediction`, input, 1: prediction that was made for this branch.
- `mispredict_count`, output, 32: running count of mispredictions.

## Operation
- Entry state: `valid` (1 bit), `tag` (`TAG_BITS`), `target` (32 bits), `ctr` (counter, width set by the configuration macro).
- Lookup, combinational:
  - `ridx = current_pc[IDX_BITS+1:2]`.
  - Hit when `valid[ridx]` is set and `tag[ridx]` equals `current_pc[31:IDX_BITS+2]`.
  - On a hit with taken-state `ctr`: `predict_taken`=1 and `target_addr`=`target[ridx]`.
  - Otherwise: `predict_taken`=0 and `target_addr`=`current_pc+4`, wrapping mod 2^32.
  - Taken-state means the counter MSB is 1.
- Update, registered, on a rising `CLK` edge when `update_predictor`=1, using `uidx` from `update_addr`:
  - Hit, `branch_result`=1: counter saturating increment; `target` ← `update_target`.
  - Hit, `branch_result`=0: counter saturating decrement; `target` unchanged.
  - Miss, `branch_result`=1: allocate (overwrite) the entry. `valid`←1, `tag`←tag of `update_addr`, `target`←`update_target`, counter←weakly taken.
  - Miss, `branch_result`=0: no state change.
- Mispredict counter: `mispredict_count` increments by 1 on every update where `prediction` != `branch_result`. It wraps from 0xFFFFFFFF to 0.
- `update_addr[1:0]` and `current_pc[1:0]` are ignored.

## Timing
- Prediction latency: 0 cycles, combinational from `current_pc` and the stored state.
- Update latency: the entry is visible to lookup in the cycle after the update edge.
- Lookup and update on the same index in the same cycle: lookup returns the pre-update state. There is no bypass.
- At most one update per cycle. No back-pressure; updates are always accepted.
- Reset, asynchronous assert:
  - All `valid`=0, all `ctr`=weakly not-taken, all `target`=0, `mispredict_count`=0.
  - Outputs during and after reset: `predict_taken`=0, `target_addr`=`current_pc+4`.
- Reset asserted mid-update: the update is lost and state equals the reset state.
- Reset deassertion: updates resume on the first rising edge with `nRST`=1.

## Configuration
- `BTB_2BIT_COUNTER_EN` defined:
  - 2-bit saturating counter: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Reset value 01; allocation value 10.
  - Saturates at 11 and 00.
- `BTB_2BIT_COUNTER_EN` not defined:
  - 1-bit last-outcome counter. Reset value 0; allocation value 1.
  - Each update sets `ctr` to `branch_result`.
- Lookup, allocation, target and mispredict-count behaviour are identical in both builds.

## Test plan
- **Reset:** drive `nRST`=0, `current_pc`=0x100 → `predict_taken`=0, `target_addr`=0x104, `mispredict_count`=0.
- **Allocate:** update `update_addr`=0x200, `update_target`=0x80, `branch_result`=1, `prediction`=0. Next cycle, `current_pc`=0x200 → `predict_taken`=1, `target_addr`=0x80, `mispredict_count`=1.
- **Hysteresis (2-bit build):** after the allocate, apply one not-taken update at 0x200 → predicts not-taken (01). Apply two taken updates → 11. Apply one not-taken update → still predicts taken at 0x80. (1-bit build: one not-taken update → not-taken.)
- **Tag alias, `NENTRIES`=16:**
  - Allocate 0x200; lookup 0x240 (same index, different tag) → miss, `target_addr`=0x244.
  - Taken update at 0x240 evicts 0x200; lookup 0x200 then misses.
- **Same-cycle collision:** with 0x200 allocated (predicts taken in both builds), apply a not-taken update at 0x200 while `current_pc`=0x200. In that cycle the prediction is the pre-update taken value (0x80). Next cycle it reflects the update.
- **Counter wrap:** preload `mispredict_count`=0xFFFFFFFF by force, apply a mispredicting update → 0x00000000. Also assert `nRST` low mid-update → all entries miss afterwards.

Source files
------------

// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters and a mispredict counter.
// Define BTB_2BIT_COUNTER_EN for 2-bit saturating counters; default is a 1-bit last-outcome counter.
module btb_branch_predictor #(
    parameter int NENTRIES = 16,
    parameter int IDX_BITS = $clog2(NENTRIES),
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] current_pc,
    output logic        predict_taken,
    output logic [31:0] target_addr,
    input  logic        update_predictor,
    input  logic [31:0] update_addr,
    input  logic [31:0] update_target,
    input  logic        branch_result,
    input  logic        prediction,
    output logic [31:0] mispredict_count
);

`ifdef BTB_2BIT_COUNTER_EN
    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_RST   = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;
`else
    localparam int CTR_W = 1;
    localparam logic [CTR_W-1:0] CTR_RST   = 1'b0;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

    logic                valid_q  [NENTRIES];
    logic                valid_d  [NENTRIES];
    logic [TAG_BITS-1:0] tag_q    [NENTRIES];
    logic [TAG_BITS-1:0] tag_d    [NENTRIES];
    logic [31:0]         target_q [NENTRIES];
    logic [31:0]         target_d [NENTRIES];
    logic [CTR_W-1:0]    ctr_q    [NENTRIES];
    logic [CTR_W-1:0]    ctr_d    [NENTRIES];
    logic [31:0]         mispredict_count_q;
    logic [31:0]         mispredict_count_d;

    logic [IDX_BITS-1:0] ridx;
    logic [TAG_BITS-1:0] rtag;
    logic                rhit;
    logic [IDX_BITS-1:0] uidx;
    logic [TAG_BITS-1:0] utag;
    logic                uhit;
    logic [1:0]          unused_update_addr_lsb;

    assign ridx = current_pc[IDX_BITS+1:2];
    assign rtag = current_pc[31:IDX_BITS+2];
    assign rhit = valid_q[ridx] && (tag_q[ridx] == rtag);

    assign uidx = update_addr[IDX_BITS+1:2];
    assign utag = update_addr[31:IDX_BITS+2];
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);
    assign unused_update_addr_lsb = update_addr[1:0];

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign predict_taken    = rhit && ctr_q[ridx][CTR_W-1];
    assign target_addr      = predict_taken ? target_q[ridx] : current_pc + 32'd4;
    assign mispredict_count = mispredict_count_q;

    always_comb begin
        valid_d            = valid_q;
        tag_d              = tag_q;
        target_d           = target_q;
        ctr_d              = ctr_q;
        mispredict_count_d = mispredict_count_q;
        if (update_predictor) begin
            if (prediction != branch_result) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
            if (uhit) begin
`ifdef BTB_2BIT_COUNTER_EN
                if (branch_result && ctr_q[uidx] != CTR_MAX) begin
                    ctr_d[uidx] = ctr_q[uidx] + 2'b01;
                end else if (!branch_result && ctr_q[uidx] != 2'b00) begin
                    ctr_d[uidx] = ctr_q[uidx] - 2'b01;
                end
`else
                ctr_d[uidx] = branch_result;
`endif
                if (branch_result) begin
                    target_d[uidx] = update_target;
                end
            end else if (branch_result) begin
                // Taken branch that misses evicts whatever occupied the slot.
                valid_d[uidx]  = 1'b1;
                tag_d[uidx]    = utag;
                target_d[uidx] = update_target;
                ctr_d[uidx]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Self-checking bench for btb_branch_predictor: directed vector table, random traffic against a reference model.
module tb_btb_branch_predictor;

    localparam int N = 16;
`ifdef BTB_2BIT_COUNTER_EN
    localparam bit TWO_BIT = 1'b1;
    localparam int M_MAX = 3, M_TAKEN = 2, M_RST = 1, M_ALLOC = 2;
`else
    localparam bit TWO_BIT = 1'b0;
    localparam int M_MAX = 1, M_TAKEN = 1, M_RST = 0, M_ALLOC = 1;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] current_pc = '0;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic        update_predictor = 1'b0;
    logic [31:0] update_addr = '0;
    logic [31:0] update_target = '0;
    logic        branch_result = 1'b0;
    logic        prediction = 1'b0;
    logic [31:0] mispredict_count;

    btb_branch_predictor #(.NENTRIES(N)) dut (
        .CLK(CLK), .nRST(nRST), .current_pc(current_pc),
        .predict_taken(predict_taken), .target_addr(target_addr),
        .update_predictor(update_predictor), .update_addr(update_addr),
        .update_target(update_target), .branch_result(branch_result),
        .prediction(prediction), .mispredict_count(mispredict_count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = M_RST;
        end
        m_cnt = '0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int unsigned i, t;
        i  = (pc / 4) % N;
        t  = pc / (4 * N);
        tk = m_valid[i] && m_tag[i] == t && m_ctr[i] >= M_TAKEN;
        tg = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic model_update();
        int unsigned i, t;
        if (!update_predictor) return;
        i = (update_addr / 4) % N;
        t = update_addr / (4 * N);
        if (prediction != branch_result) m_cnt = m_cnt + 32'd1;
        if (m_valid[i] && m_tag[i] == t) begin
            if (branch_result) begin
                m_ctr[i] = (m_ctr[i] + 1 > M_MAX) ? M_MAX : m_ctr[i] + 1;
                m_target[i] = update_target;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (branch_result) begin
            m_valid[i] = 1; m_tag[i] = t; m_target[i] = update_target; m_ctr[i] = M_ALLOC;
        end
    endtask

    task automatic drive(input logic [31:0] pc, input bit upd, input logic [31:0] ua,
                         input logic [31:0] ut, input bit br, input bit pr);
        @(negedge CLK);
        current_pc = pc; update_predictor = upd; update_addr = ua;
        update_target = ut; branch_result = br; prediction = pr;
        #1;
    endtask

    task automatic commit();
        @(posedge CLK);
        if (nRST) model_update();
    endtask

    task automatic chk_model(input string nm);
        bit tk;
        logic [31:0] tg;
        model_lookup(current_pc, tk, tg);
        chk({nm, ".taken"}, {31'b0, predict_taken}, {31'b0, tk});
        chk({nm, ".target"}, target_addr, tg);
        chk({nm, ".count"}, mispredict_count, m_cnt);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          upd;
        logic [31:0] ua;
        logic [31:0] ut;
        bit          br;
        bit          pr;
        bit          exp_tk;
        logic [31:0] exp_tg;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, bit upd, logic [31:0] ua, logic [31:0] ut,
                                bit br, bit pr, bit tk, logic [31:0] tg, logic [31:0] cnt);
        vec_t v;
        v.pc = pc; v.upd = upd; v.ua = ua; v.ut = ut; v.br = br; v.pr = pr;
        v.exp_tk = tk; v.exp_tg = tg; v.exp_cnt = cnt;
        return v;
    endfunction

    vec_t vecs [14];

    initial begin
        vecs[0]  = mk(32'h100, 1, 32'h200, 32'h80, 1, 0, 0, 32'h104, 0);
        vecs[1]  = mk(32'h200, 0, 0, 0, 0, 0, 1, 32'h80, 1);
        vecs[2]  = mk(32'h240, 0, 0, 0, 0, 0, 0, 32'h244, 1);
        vecs[3]  = mk(32'h200, 1, 32'h200, 32'h80, 0, 1, 1, 32'h80, 1);
        vecs[4]  = mk(32'h200, 0, 0, 0, 0, 0, 0, 32'h204, 2);
        vecs[5]  = mk(32'h200, 1, 32'h200, 32'h80, 1, 0, 0, 32'h204, 2);
        vecs[6]  = mk(32'h200, 1, 32'h200, 32'h88, 1, 1, 1, 32'h80, 3);
        vecs[7]  = mk(32'h200, 1, 32'h200, 32'h88, 0, 1, 1, 32'h88, 3);
        vecs[8]  = mk(32'h200, 0, 0, 0, 0, 0, TWO_BIT, TWO_BIT ? 32'h88 : 32'h204, 4);
        vecs[9]  = mk(32'h200, 1, 32'h241, 32'h300, 1, 1, TWO_BIT, TWO_BIT ? 32'h88 : 32'h204, 4);
        vecs[10] = mk(32'h202, 0, 0, 0, 0, 0, 0, 32'h206, 4);
        vecs[11] = mk(32'h240, 1, 32'h104, 32'h500, 0, 0, 1, 32'h300, 4);
        vecs[12] = mk(32'h104, 0, 0, 0, 0, 0, 0, 32'h108, 4);
        vecs[13] = mk(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 4);

        model_reset();
        current_pc = 32'h100;
        #3;
        chk("reset.taken", {31'b0, predict_taken}, 32'd0);
        chk("reset.target", target_addr, 32'h104);
        chk("reset.count", mispredict_count, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int k = 0; k < 14; k++) begin
            drive(vecs[k].pc, vecs[k].upd, vecs[k].ua, vecs[k].ut, vecs[k].br, vecs[k].pr);
            chk($sformatf("vec%0d.taken", k), {31'b0, predict_taken}, {31'b0, vecs[k].exp_tk});
            chk($sformatf("vec%0d.target", k), target_addr, vecs[k].exp_tg);
            chk($sformatf("vec%0d.count", k), mispredict_count, vecs[k].exp_cnt);
            commit();
        end

        for (int k = 0; k < 400; k++) begin
            logic [31:0] pc, ua;
            pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            ua = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
            drive(pc, $urandom_range(0, 9) < 7, ua, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
            chk_model($sformatf("rand%0d", k));
            commit();
        end

        // Counter wrap: preload all-ones, then one mispredicting update.
        @(negedge CLK);
        update_predictor = 1'b0;
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(32'h200, 1, 32'h3C0, 32'h10, 0, 1);
        chk_model("wrap.pre");
        commit();
        drive(32'h200, 0, 0, 0, 0, 0);
        chk("wrap.count", mispredict_count, 32'h0);
        commit();

        // Guarantee at least one live entry, then reset in the middle of an update.
        drive(32'h200, 1, 32'h200, 32'h80, 1, 1);
        commit();
        drive(32'h200, 1, 32'h3C0, 32'h1234, 1, 0);
        chk("midrst.pre_taken", {31'b0, predict_taken}, 32'd1);
        #1 nRST = 1'b0;
        model_reset();
        #1;
        chk("midrst.count", mispredict_count, 32'd0);
        @(posedge CLK);
        #1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                current_pc = (t << 6) | (i << 2);
                #1;
                chk($sformatf("midrst.miss_t%0d_i%0d", t, i), {31'b0, predict_taken}, 32'd0);
            end
        end
        chk("midrst.target", target_addr, current_pc + 32'd4);
        update_predictor = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        drive(32'h3C0, 1, 32'h3C0, 32'h1234, 1, 1);
        chk_model("resume.pre");
        commit();
        drive(32'h3C0, 0, 0, 0, 0, 0);
        chk("resume.taken", {31'b0, predict_taken}, 32'd1);
        chk("resume.target", target_addr, 32'h1234);
        chk_model("resume.post");
        commit();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
